// File: rtl/mem_io_pkg.sv
// Shared definitions for the data-memory / IO arbiter.
// Contents: FSM state encoding, default IO region base, master identifiers
// and the address-region decode helper.
package mem_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM_ACC = 2'd1,
    ST_IO_ACC  = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  // addr[31:10] equal to this selects the IO window 0xFFFFFC00..0xFFFFFFFF
  localparam logic [21:0] IO_BASE = 22'h3FFFFF;

  localparam logic M0_ID = 1'b0;  // CPU load/store path
  localparam logic M1_ID = 1'b1;  // UART loader

  // True when the byte address falls inside the IO window
  function automatic logic addr_is_io(input logic [31:0] addr, input logic [21:0] base);
    return (addr[31:10] == base);
  endfunction

endpackage

// File: rtl/mem_io_arb_pick.sv
// Two-way grant selector for mem_io_arbiter.
// Build option: MEM_IO_ARB_RR_EN
//   undefined -> fixed priority, M1 beats M0 on a collision (no state).
//   defined   -> round-robin, the master not granted last wins a collision;
//                the last-grant pointer resets to M0 and updates on every grant.
// Ports:
//   clk, rst_n, upd  (round-robin build only) pointer clock, sync active-low
//                    reset, grant-taken strobe
//   req0, req1       request levels of M0 / M1
//   gnt_valid        at least one request present
//   gnt_id           winning master (M0_ID / M1_ID)
module mem_io_arb_pick
  import mem_io_pkg::*;
(
`ifdef MEM_IO_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic upd,
`endif
  input  logic req0,
  input  logic req1,
  output logic gnt_valid,
  output logic gnt_id
);

`ifdef MEM_IO_ARB_RR_EN
  logic last_r;

  // Remember which master was granted most recently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r <= M0_ID;
    end else if (upd) begin
      last_r <= gnt_id;
    end else begin
      last_r <= last_r;
    end
  end

  // Round-robin choice: on a collision hand the grant to the other master
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = M0_ID;
    if (req0 && req1) begin
      gnt_id = ~last_r;
    end else if (req1) begin
      gnt_id = M1_ID;
    end else begin
      gnt_id = M0_ID;
    end
  end
`else
  // Fixed priority: the loader always wins a collision
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = M0_ID;
    if (req1) begin
      gnt_id = M1_ID;
    end else begin
      gnt_id = M0_ID;
    end
  end
`endif

endmodule

// File: rtl/mem_io_arbiter.sv
// Shares the data-memory port and the LED/switch IO bus between the CPU
// load/store path (M0) and the UART loader (M1). One access in flight;
// each access is decoded to MEM or IO, sequenced, and answered with a
// one-cycle ack carrying the read data.
// Build option: MEM_IO_ARB_RR_EN selects round-robin arbitration
// (default build: fixed priority M1 > M0).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   m0_req/we/addr/wdata       CPU request (req held until ack)
//   m0_rdata, m0_ack           CPU read data and completion pulse
//   m1_*                       same for the loader
//   mem_en/we/addr/wdata       dmem strobe, write enable, word address, data
//   mem_rdata                  dmem read data (MEM_LAT cycles after mem_en)
//   io_en/we/addr/wdata        IO strobe, write, addr[7:0], wdata[15:0]
//   io_rdata                   IO read data (16 bit, zero-extended on return)
//   busy                       FSM not idle
module mem_io_arbiter
  import mem_io_pkg::*;
#(
  parameter int          MEM_LAT = 1,
  parameter int          IO_WAIT = 2,
  parameter int          MEM_AW  = 14,
  parameter logic [21:0] IO_BASE = mem_io_pkg::IO_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic [31:0]       m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic [31:0]       m1_rdata,
  output logic              m1_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              io_en,
  output logic              io_we,
  output logic [7:0]        io_addr,
  output logic [15:0]       io_wdata,
  input  logic [15:0]       io_rdata,
  output logic              busy
);

  localparam logic [3:0] MEM_CNT = 4'(MEM_LAT);
  localparam logic [3:0] IO_CNT  = 4'(IO_WAIT);

  arb_state_t  state_r;
  logic [3:0]  cnt_r;
  logic        id_r;
  logic        we_r;

  logic        gnt_valid_s;
  logic        gnt_id_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_io_s;
  logic [31:0] cap_s;

  mem_io_arb_pick u_pick (
`ifdef MEM_IO_ARB_RR_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .upd       ((state_r == ST_IDLE) && gnt_valid_s),
`endif
    .req0      (m0_req),
    .req1      (m1_req),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // Route the winning master's request fields and decode its region
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = 32'h0000_0000;
    sel_wdata_s = 32'h0000_0000;
    if (gnt_id_s == M1_ID) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
    sel_io_s = addr_is_io(sel_addr_s, IO_BASE);
  end

  // Value returned on completion: reads only, IO data zero-extended
  always_comb begin
    cap_s = 32'h0000_0000;
    if (we_r) begin
      cap_s = 32'h0000_0000;
    end else if (state_r == ST_IO_ACC) begin
      cap_s = {16'h0000, io_rdata};
    end else begin
      cap_s = mem_rdata;
    end
  end

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      id_r      <= M0_ID;
      we_r      <= 1'b0;
      m0_rdata  <= 32'h0000_0000;
      m0_ack    <= 1'b0;
      m1_rdata  <= 32'h0000_0000;
      m1_ack    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0000_0000;
      io_en     <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= 8'h00;
      io_wdata  <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      // strobes and acks are single-cycle pulses unless set below
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      io_en    <= 1'b0;
      io_we    <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= 32'h0000_0000;
      m1_rdata <= 32'h0000_0000;
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            id_r  <= gnt_id_s;
            we_r  <= sel_we_s;
            cnt_r <= 4'd0;
            busy  <= 1'b1;
            if (sel_io_s) begin
              state_r  <= ST_IO_ACC;
              io_en    <= 1'b1;
              io_we    <= sel_we_s;
              io_addr  <= sel_addr_s[7:0];
              io_wdata <= sel_wdata_s[15:0];
            end else begin
              state_r   <= ST_MEM_ACC;
              mem_en    <= 1'b1;
              mem_we    <= sel_we_s;
              mem_addr  <= sel_addr_s[MEM_AW+1:2];
              mem_wdata <= sel_wdata_s;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_MEM_ACC, ST_IO_ACC: begin
          // the strobe is still high in the entry cycle: load the wait count there
          if (mem_en || io_en) begin
            cnt_r <= (state_r == ST_IO_ACC) ? IO_CNT : MEM_CNT;
          end else if (cnt_r == 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= ST_RESP;
            if (id_r == M1_ID) begin
              m1_ack   <= 1'b1;
              m1_rdata <= cap_s;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= cap_s;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Directed self-checking bench for mem_io_arbiter (MEM_LAT=1, IO_WAIT=2).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_mem_io_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        mem_en, mem_we, io_en, io_we, busy;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata, io_rdata;

  int checks = 0;
  int fails  = 0;

  mem_io_arbiter #(.MEM_LAT(1), .IO_WAIT(2), .MEM_AW(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    mem_rdata = 32'h0; io_rdata = 16'h0;
    tick(); tick();
    checks++;
    if ({mem_en, mem_we, io_en, io_we, busy, m0_ack, m1_ack} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b exp 0000000", {mem_en, mem_we, io_en, io_we, busy, m0_ack, m1_ack});
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0 || mem_addr !== 14'h0 || io_addr !== 8'h0) begin
      fails++; $display("FAIL reset_data: m0_rdata=%h m1_rdata=%h mem_addr=%h io_addr=%h exp all 0", m0_rdata, m1_rdata, mem_addr, io_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mem_read();
    mem_rdata = 32'hDEADBEEF;
    m0_we = 1'b0; m0_addr = 32'h0000_0010; m0_req = 1'b1;
    tick();  // cycle 1
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 14'd4) begin
      fails++; $display("FAIL mem_read_strobe: en=%b we=%b addr=%h exp 1 0 0004", mem_en, mem_we, mem_addr);
    end
    checks++;
    if (io_en !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL mem_read_busy: io_en=%b busy=%b exp 0 1", io_en, busy);
    end
    tick();  // cycle 2
    checks++;
    if (m0_ack !== 1'b0 || mem_en !== 1'b0) begin
      fails++; $display("FAIL mem_read_c2: ack=%b mem_en=%b exp 0 0", m0_ack, mem_en);
    end
    tick();  // cycle 3
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL mem_read_ack: ack=%b rdata=%h exp 1 deadbeef", m0_ack, m0_rdata);
    end
    checks++;
    if (m1_ack !== 1'b0 || m1_rdata !== 32'h0) begin
      fails++; $display("FAIL mem_read_other: m1_ack=%b m1_rdata=%h exp 0 0", m1_ack, m1_rdata);
    end
    m0_req = 1'b0;
    tick();  // cycle 4
    checks++;
    if (m0_ack !== 1'b0 || busy !== 1'b0 || m0_rdata !== 32'h0) begin
      fails++; $display("FAIL mem_read_end: ack=%b busy=%b rdata=%h exp 0 0 0", m0_ack, busy, m0_rdata);
    end
  endtask

  task automatic test_io_write();
    logic saw_mem = 1'b0;
    logic early   = 1'b0;
    m1_we = 1'b1; m1_addr = 32'hFFFF_FC60; m1_wdata = 32'h0000_A5A5; m1_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (mem_en) saw_mem = 1'b1;
      if (c < 4 && m1_ack) early = 1'b1;
      if (c == 1) begin
        checks++;
        if (io_en !== 1'b1 || io_we !== 1'b1 || io_addr !== 8'h60 || io_wdata !== 16'hA5A5) begin
          fails++; $display("FAIL io_write_strobe: en=%b we=%b addr=%h wdata=%h exp 1 1 60 a5a5", io_en, io_we, io_addr, io_wdata);
        end
      end
    end
    checks++;
    if (m1_ack !== 1'b1 || early !== 1'b0 || m1_rdata !== 32'h0 || m0_ack !== 1'b0) begin
      fails++; $display("FAIL io_write_ack: ack=%b early=%b rdata=%h m0_ack=%b exp 1 0 0 0", m1_ack, early, m1_rdata, m0_ack);
    end
    checks++;
    if (saw_mem !== 1'b0) begin
      fails++; $display("FAIL io_write_nomem: mem_en seen=%b exp 0", saw_mem);
    end
    m1_req = 1'b0; m1_we = 1'b0;
    tick();
  endtask

  task automatic test_io_read();
    io_rdata = 16'h8001;
    m0_we = 1'b0; m0_addr = 32'hFFFF_FC70; m0_req = 1'b1;
    tick();  // cycle 1
    checks++;
    if (io_en !== 1'b1 || io_we !== 1'b0 || io_addr !== 8'h70 || mem_en !== 1'b0) begin
      fails++; $display("FAIL io_read_strobe: io_en=%b io_we=%b addr=%h mem_en=%b exp 1 0 70 0", io_en, io_we, io_addr, mem_en);
    end
    tick(); tick(); tick();  // cycle 4
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h0000_8001) begin
      fails++; $display("FAIL io_read_ack: ack=%b rdata=%h exp 1 00008001", m0_ack, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_mem_write();
    mem_rdata = 32'h1111_1111;
    m1_we = 1'b1; m1_addr = 32'h0000_1237; m1_wdata = 32'hCAFE_F00D; m1_req = 1'b1;
    tick();  // cycle 1
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 14'h048D || mem_wdata !== 32'hCAFEF00D) begin
      fails++; $display("FAIL mem_write_strobe: en=%b we=%b addr=%h wdata=%h exp 1 1 048d cafef00d", mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick(); tick();  // cycle 3
    checks++;
    if (m1_ack !== 1'b1 || m1_rdata !== 32'h0) begin
      fails++; $display("FAIL mem_write_ack: ack=%b rdata=%h exp 1 0", m1_ack, m1_rdata);
    end
    m1_req = 1'b0; m1_we = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    mem_rdata = 32'h0BAD_F00D;
    m0_we = 1'b0; m0_addr = 32'h0000_0020; m0_req = 1'b1;
    tick();  // cycle 1, memory access in progress
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || m0_ack !== 1'b0) begin
      fails++; $display("FAIL midreset_state: busy=%b mem_en=%b ack=%b exp 0 0 0", busy, mem_en, m0_ack);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (m0_ack) begin n = i; break; end
    end
    checks++;
    if (n !== 3 || m0_rdata !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL midreset_reissue: ack after %0d cycles rdata=%h exp 3 0badf00d", n, m0_rdata);
    end
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_req_drop();
    int acks = 0;
    mem_rdata = 32'h5555_AAAA;
    m0_we = 1'b0; m0_addr = 32'h0000_0040; m0_req = 1'b1;
    tick();  // cycle 1, granted
    m0_req = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (m0_ack) acks++;
      if (c == 3) begin
        checks++;
        if (m0_ack !== 1'b1 || busy !== 1'b1 || m0_rdata !== 32'h5555_AAAA) begin
          fails++; $display("FAIL drop_ack: ack=%b busy=%b rdata=%h exp 1 1 5555aaaa", m0_ack, busy, m0_rdata);
        end
      end
      if (c == 4) begin
        checks++;
        if (busy !== 1'b0) begin
          fails++; $display("FAIL drop_busy: busy=%b exp 0", busy);
        end
      end
    end
    checks++;
    if (acks !== 1) begin
      fails++; $display("FAIL drop_ack_count: got %0d exp 1", acks);
    end
  endtask

  task automatic test_back_to_back();
    int rem0 = 3;
    int rem1 = 3;
    int got[$];
    int exp_order[6];
    logic both = 1'b0;
    logic bad_data = 1'b0;
`ifdef MEM_IO_ARB_RR_EN
    exp_order = '{1, 0, 1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 0, 0, 0};
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mem_rdata = 32'h1234_5678;
    m0_we = 1'b0; m0_addr = 32'h0000_0100;
    m1_we = 1'b0; m1_addr = 32'h0000_0200;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 100 && (rem0 + rem1) > 0; c++) begin
      tick();
      if (m0_ack && m1_ack) both = 1'b1;
      if (m0_ack) begin
        got.push_back(0); rem0--; m0_req = 1'b0;
        if (m0_rdata !== 32'h1234_5678) bad_data = 1'b1;
      end else if (!m0_req && rem0 > 0) begin
        m0_req = 1'b1;
      end
      if (m1_ack) begin
        got.push_back(1); rem1--; m1_req = 1'b0;
        if (m1_rdata !== 32'h1234_5678) bad_data = 1'b1;
      end else if (!m1_req && rem1 > 0) begin
        m1_req = 1'b1;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++;
    if (got.size() !== 6) begin
      fails++; $display("FAIL b2b_count: got %0d acks exp 6 (timeout)", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_order[i]) begin
        fails++; $display("FAIL b2b_order[%0d]: got M%0d exp M%0d", i, got[i], exp_order[i]);
      end
    end
    checks++;
    if (both !== 1'b0 || bad_data !== 1'b0) begin
      fails++; $display("FAIL b2b_ack: dual_ack=%b bad_data=%b exp 0 0", both, bad_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_io_read();
    test_mem_write();
    test_reset_midflight();
    test_req_drop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
